// File: rtl/row_sweep_controller.sv
// Player-block sequencer for the stacking game: loads rows, sweeps and bounces the block,
// handshakes erase/draw with the pixel drawer and commits rows. Optional macro: ROW_SPEEDUP_EN.
module row_sweep_controller #(
  parameter int X_INIT    = 0,
  parameter int X_END     = 144,
  parameter int STEP      = 4,
  parameter int Y_ROW0    = 104,
  parameter int ROW_PITCH = 16,
  parameter int NUM_ROWS  = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       place,
  input  logic       move_tick,
  input  logic       draw_done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       direction,
  output logic       draw_req,
  output logic       erase,
  output logic       inc_row,
  output logic [2:0] row,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_WAIT,
    S_ERASE,
    S_STEP,
    S_PLACE,
    S_DONE
  } state_t;

  localparam logic [7:0] X_LO     = 8'(X_INIT);
  localparam logic [7:0] X_HI     = 8'(X_END);
  localparam logic [6:0] Y_BASE   = 7'(Y_ROW0);
  localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);

  state_t     state;
  logic       place_pend;
  logic [8:0] step_eff;
  logic [8:0] x_right;
  logic [8:0] x_left_min;
  logic [7:0] step_x;
  logic       step_dir;

  function automatic logic [6:0] row_y(input logic [2:0] r);
    logic [9:0] off;
    off = 10'(r) * 10'(ROW_PITCH);
    return 7'(10'(Y_ROW0) - off);
  endfunction

  always_comb begin
`ifdef ROW_SPEEDUP_EN
    step_eff = 9'(STEP) + {5'd0, row, 1'b0};
`else
    step_eff = 9'(STEP);
`endif
  end

  // Bounce arithmetic is done one bit wider so neither edge test can wrap.
  always_comb begin
    x_right    = {1'b0, x} + step_eff;
    x_left_min = 9'(X_INIT) + step_eff;
    step_x     = x;
    step_dir   = direction;
    if (direction) begin
      if (x_right >= 9'(X_END)) begin
        step_x   = X_HI;
        step_dir = 1'b0;
      end else begin
        step_x = x_right[7:0];
      end
    end else begin
      if ({1'b0, x} < x_left_min) begin
        step_x   = X_LO;
        step_dir = 1'b1;
      end else begin
        step_x = x - step_eff[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      x          <= X_LO;
      y          <= Y_BASE;
      direction  <= 1'b1;
      row        <= 3'd0;
      draw_req   <= 1'b0;
      erase      <= 1'b0;
      inc_row    <= 1'b0;
      game_over  <= 1'b0;
      place_pend <= 1'b0;
    end else begin
      inc_row <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            row   <= 3'd0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (place) place_pend <= 1'b1;
          y         <= row_y(row);
          x         <= row[0] ? X_HI : X_LO;
          direction <= ~row[0];
          draw_req  <= 1'b1;
          erase     <= 1'b0;
          state     <= S_DRAW;
        end
        S_DRAW: begin
          if (place) place_pend <= 1'b1;
          if (draw_done) begin
            draw_req <= 1'b0;
            state    <= S_WAIT;
          end
        end
        // A commit outranks a coincident tick; that tick is simply lost.
        S_WAIT: begin
          if (place || place_pend) begin
            inc_row    <= 1'b1;
            place_pend <= 1'b0;
            state      <= S_PLACE;
          end else if (move_tick) begin
            draw_req <= 1'b1;
            erase    <= 1'b1;
            state    <= S_ERASE;
          end
        end
        S_ERASE: begin
          if (place) place_pend <= 1'b1;
          if (draw_done) begin
            draw_req <= 1'b0;
            erase    <= 1'b0;
            state    <= S_STEP;
          end
        end
        S_STEP: begin
          if (place) place_pend <= 1'b1;
          x         <= step_x;
          direction <= step_dir;
          draw_req  <= 1'b1;
          erase     <= 1'b0;
          state     <= S_DRAW;
        end
        S_PLACE: begin
          if (row == LAST_ROW) begin
            game_over <= 1'b1;
            state     <= S_DONE;
          end else begin
            row   <= row + 3'd1;
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          if (start) begin
            game_over <= 1'b0;
            row       <= 3'd0;
            state     <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_sweep_controller.sv
// Self-checking bench for row_sweep_controller: table of row commits plus hand-written
// sequences, with a scoreboard of expected block positions compared at each new draw.
module tb_row_sweep_controller;

  localparam int X_INIT = 0;
  localparam int X_END  = 144;
  localparam int STEP   = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start, place, move_tick, draw_done;
  logic [7:0] x;
  logic [6:0] y;
  logic       direction, draw_req, erase, inc_row, game_over;
  logic [2:0] row;

  typedef struct {
    int x;
    int y;
    int dir;
  } exp_t;

  typedef struct {
    bit coTick;
    int expRow;
    int expY;
    int expX;
    int expDir;
    bit expOver;
    bit tickAfter;
  } vec_t;

  exp_t sbQueue[$];
  vec_t tbl[5];
  int   nChecks = 0;
  int   nFails  = 0;
  int   mx, md, mrow, hx;

  row_sweep_controller dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .place     (place),
    .move_tick (move_tick),
    .draw_done (draw_done),
    .x         (x),
    .y         (y),
    .direction (direction),
    .draw_req  (draw_req),
    .erase     (erase),
    .inc_row   (inc_row),
    .row       (row),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pulse inputs are presented for exactly one rising edge; outputs are read 1 ns after it.
  task automatic applyStimulus(input bit s, input bit p, input bit t, input bit d);
    start = s; place = p; move_tick = t; draw_done = d;
    @(posedge clk);
    #1;
    start = 0; place = 0; move_tick = 0; draw_done = 0;
  endtask

  function automatic int effStep(input int r);
`ifdef ROW_SPEEDUP_EN
    return STEP + 2 * r;
`else
    return STEP;
`endif
  endfunction

  task automatic modelStep();
    int s;
    s = effStep(mrow);
    if (md == 1) begin
      if (mx + s >= X_END) begin mx = X_END; md = 0; end
      else mx = mx + s;
    end else begin
      if (mx < X_INIT + s) begin mx = X_INIT; md = 1; end
      else mx = mx - s;
    end
  endtask

  task automatic pushExp(input int ex, input int ey, input int ed);
    exp_t e;
    e.x = ex; e.y = ey; e.dir = ed;
    sbQueue.push_back(e);
  endtask

  // Waits for a request, checks it, holds it two cycles, then returns draw_done.
  task automatic serveDraw(input bit expErase, input bit tickInDraw, input string tag);
    int   waited;
    exp_t e;
    waited = 0;
    while (draw_req !== 1'b1 && waited < 20) begin
      applyStimulus(0, 0, 0, 0);
      waited++;
    end
    if (draw_req !== 1'b1) begin
      checkOutput({tag, "_req_timeout"}, 0, 1);
      return;
    end
    checkOutput({tag, "_erase"}, erase, expErase);
    if (!expErase) begin
      if (sbQueue.size() == 0) begin
        checkOutput({tag, "_sb_underflow"}, 0, 1);
      end else begin
        e = sbQueue.pop_front();
        checkOutput({tag, "_x"}, x, e.x);
        checkOutput({tag, "_y"}, y, e.y);
        checkOutput({tag, "_dir"}, direction, e.dir);
      end
    end
    hx = x;
    applyStimulus(0, 0, tickInDraw, 0);
    checkOutput({tag, "_req_hold1"}, draw_req, 1);
    checkOutput({tag, "_x_stable"}, x, hx);
    applyStimulus(0, 0, 0, 0);
    checkOutput({tag, "_req_hold2"}, draw_req, 1);
    checkOutput({tag, "_erase_stable"}, erase, expErase);
    applyStimulus(0, 0, 0, 1);
    checkOutput({tag, "_req_drop"}, draw_req, 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_x"}, x, X_INIT);
    checkOutput({tag, "_y"}, y, 104);
    checkOutput({tag, "_dir"}, direction, 1);
    checkOutput({tag, "_row"}, row, 0);
    checkOutput({tag, "_draw_req"}, draw_req, 0);
    checkOutput({tag, "_erase"}, erase, 0);
    checkOutput({tag, "_inc_row"}, inc_row, 0);
    checkOutput({tag, "_game_over"}, game_over, 0);
  endtask

  initial begin
    tbl[0] = '{0, 3, 56, 144, 0, 0, 1};
    tbl[1] = '{1, 4, 40,   0, 1, 0, 0};
    tbl[2] = '{0, 5, 24, 144, 0, 0, 0};
    tbl[3] = '{1, 6,  8,   0, 1, 0, 0};
    tbl[4] = '{0, 6,  8,   0, 1, 1, 0};

    resetn = 0; start = 0; place = 0; move_tick = 0; draw_done = 0;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkResetState("reset");
    resetn = 1;

    $display("[TB] idle ignores place, then start row 0");
    applyStimulus(0, 1, 1, 0);
    checkOutput("idle_place_inc_row", inc_row, 0);
    checkOutput("idle_no_req", draw_req, 0);
    mx = 0; md = 1; mrow = 0;
    pushExp(mx, 104, md);
    applyStimulus(1, 0, 0, 0);
    checkOutput("load_no_req_yet", draw_req, 0);
    serveDraw(0, 0, "first_draw");

    $display("[TB] sweep row 0 to the right edge and back");
    for (int t = 1; t <= 37; t++) begin
      modelStep();
      pushExp(mx, 104, md);
      applyStimulus(0, 0, 1, 0);
      serveDraw(1, 0, "sweep_erase");
      serveDraw(0, 0, "sweep_draw");
      if (t == 36) begin
        checkOutput("tick36_x", x, 144);
        checkOutput("tick36_dir", direction, 0);
      end
    end
    checkOutput("tick37_x", x, 140);

    $display("[TB] start in WAIT is ignored");
    applyStimulus(1, 0, 0, 0);
    checkOutput("wait_start_req", draw_req, 0);
    checkOutput("wait_start_row", row, 0);

    $display("[TB] place coincident with tick");
    applyStimulus(0, 1, 1, 0);
    checkOutput("co_inc_row", inc_row, 1);
    checkOutput("co_no_erase_req", draw_req, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("co_inc_row_drop", inc_row, 0);
    checkOutput("co_req_early", draw_req, 0);
    mx = 144; md = 0; mrow = 1;
    pushExp(mx, 88, md);
    applyStimulus(0, 0, 0, 0);
    checkOutput("co_req_latency", draw_req, 1);
    checkOutput("co_row", row, 1);
    serveDraw(0, 0, "row1_draw");

    $display("[TB] place during ERASE is remembered");
    modelStep();
    pushExp(mx, 88, md);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("pend_in_erase", erase, 1);
    serveDraw(1, 0, "pend_erase");
    serveDraw(0, 0, "pend_draw");
    applyStimulus(0, 0, 0, 0);
    checkOutput("pend_inc_row", inc_row, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("pend_inc_row_once", inc_row, 0);
    checkOutput("pend_row", row, 2);
    mx = 0; md = 1; mrow = 2;
    pushExp(mx, 72, md);
    serveDraw(0, 1, "row2_draw");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("tick_in_draw_dropped", draw_req, 0);
    end

    $display("[TB] table of remaining commits");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, tbl[i].coTick, 0);
      checkOutput("tbl_inc_row", inc_row, 1);
      checkOutput("tbl_no_req", draw_req, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("tbl_inc_row_drop", inc_row, 0);
      checkOutput("tbl_row", row, tbl[i].expRow);
      checkOutput("tbl_game_over", game_over, tbl[i].expOver);
      if (!tbl[i].expOver) begin
        mx = tbl[i].expX; md = tbl[i].expDir; mrow = tbl[i].expRow;
        pushExp(mx, tbl[i].expY, md);
        serveDraw(0, 0, "tbl_load");
        if (tbl[i].tickAfter) begin
          modelStep();
          pushExp(mx, tbl[i].expY, md);
          applyStimulus(0, 0, 1, 0);
          serveDraw(1, 0, "tbl_erase");
          serveDraw(0, 0, "tbl_step");
`ifdef ROW_SPEEDUP_EN
          checkOutput("row3_step_x", x, 134);
`else
          checkOutput("row3_step_x", x, 140);
`endif
        end
      end else begin
        checkOutput("done_y_hold", y, tbl[i].expY);
        checkOutput("done_x_hold", x, tbl[i].expX);
        checkOutput("done_no_req", draw_req, 0);
      end
    end

    $display("[TB] DONE ignores place and tick, restarts on start");
    applyStimulus(0, 1, 1, 0);
    checkOutput("done_place_inc_row", inc_row, 0);
    checkOutput("done_still_over", game_over, 1);
    checkOutput("done_tick_no_req", draw_req, 0);
    mx = 0; md = 1; mrow = 0;
    pushExp(mx, 104, md);
    applyStimulus(1, 0, 0, 0);
    checkOutput("restart_over_clear", game_over, 0);
    checkOutput("restart_row", row, 0);
    serveDraw(0, 0, "restart_draw");

    $display("[TB] reset in the middle of a draw");
    applyStimulus(0, 0, 1, 0);
    serveDraw(1, 0, "rst_erase");
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_pre_req", draw_req, 1);
    resetn = 0;
    applyStimulus(1, 1, 1, 1);
    checkResetState("mid_draw_reset");
    resetn = 1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("rst_stays_idle", draw_req, 0);
    end
    pushExp(0, 104, 1);
    applyStimulus(1, 0, 0, 0);
    serveDraw(0, 0, "post_reset_draw");

    checkOutput("sb_drained", sbQueue.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/row_sweep_controller.md
Name: row_sweep_controller

Overview:
- Sequences the player block in the stacking game.
- Loads each row's start position and direction, and steps the block horizontally on each move tick, bouncing at the row edges.
- Drives an erase/draw handshake to the VGA drawer.
- On a place press, commits the row and advances to the next row, up to the top row.
- Sits between the game input logic (tick divider, debounced key) and the pixel drawer.

Parameters:
- X_INIT, 0, left-edge x (8 bits)
- X_END, 144, right-edge x (8 bits)
- STEP, 4, x pixels per move tick
- Y_ROW0, 104, y of row 0 (7 bits)
- ROW_PITCH, 16, y decrement per row
- NUM_ROWS, 7, number of rows; the last row is NUM_ROWS-1

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  1-cycle pulse; begins a game from IDLE or DONE
- place  in  1  1-cycle pulse; player commits block in current row
- move_tick  in  1  1-cycle pulse; advance block one step
- draw_done  in  1  1-cycle pulse from drawer; current draw/erase finished
- x  out  8  block x position
- y  out  7  block y position
- direction  out  1  1 = moving right, 0 = moving left
- draw_req  out  1  level; held high until draw_done
- erase  out  1  valid while draw_req is high; 1 = paint background, 0 = paint block
- inc_row  out  1  1-cycle pulse when a row is committed
- row  out  3  current row index
- game_over  out  1  high in DONE

Behaviour:
- Reset (resetn=0 at a clk edge), from any state, mid-draw included:
  - state=IDLE.
  - x=X_INIT, y=Y_ROW0, direction=1, row=0.
  - draw_req=0, erase=0, inc_row=0, game_over=0, place_pend=0.
  - Reset has priority over all inputs.
- Row mapping:
  - y = Y_ROW0 - row*ROW_PITCH (row 0=104, row 6=8).
  - Even row: x=X_INIT, direction=1.
  - Odd row: x=X_END, direction=0.
- States:
  - IDLE: on start -> LOAD.
  - LOAD (1 cycle): apply the row mapping -> DRAW.
  - DRAW: draw_req=1, erase=0; on draw_done -> WAIT. draw_req drops the cycle after draw_done.
  - WAIT:
    - place or place_pend -> PLACE.
    - else move_tick -> ERASE.
    - Place wins over a simultaneous tick; the tick is dropped.
  - ERASE: draw_req=1, erase=1; on draw_done -> STEP.
  - STEP (1 cycle): update x per the arithmetic below -> DRAW.
  - PLACE (1 cycle):
    - inc_row=1, clear place_pend.
    - If row==NUM_ROWS-1 -> DONE, row unchanged.
    - Else row<=row+1 -> LOAD.
  - DONE: game_over=1, x/y hold; on start -> row=0, LOAD.
- Step arithmetic, computed in 9 bits (no wrap):
  - Right: if x+STEP >= X_END, then x=X_END and direction<=0; else x=x+STEP.
  - Left: if x < X_INIT+STEP, then x=X_INIT and direction<=1; else x=x-STEP.
- Place during DRAW/ERASE/STEP/LOAD: set place_pend; serviced on entry to WAIT.
- move_tick outside WAIT is ignored and not queued.
- place in IDLE/DONE is ignored.
- start outside IDLE/DONE is ignored.
- Latency: place in WAIT -> inc_row exactly 1 cycle later -> next row's draw_req 2 cycles after inc_row.
- draw_req never deasserts before draw_done; x, y and erase are stable while draw_req=1.

Optional Feature:
- Macro: ROW_SPEEDUP_EN.
- Defined: effective step = STEP + 2*row (row 0=4, row 6=16); bounce rules use the effective step.
- Undefined: step is constant STEP on every row.

Test Plan:
- Reset, then start; return draw_done after 3 cycles -> LOAD gives x=0, y=104, direction=1; draw_req high until draw_done; state WAIT.
- In row 0 WAIT, 36 move_ticks each with erase/draw completion -> after tick 36, x=144 and direction=0; tick 37 -> x=140.
- place coincident with move_tick in WAIT -> inc_row pulse next cycle, no erase cycle, row=1, y=88, x=144, direction=0.
- place asserted during ERASE -> after draw_done and the redraw, PLACE is entered without a second place; inc_row fires exactly once.
- Seven commits from row 0 -> after 7th inc_row, game_over=1 and row=6; start -> row=0, y=104.
- resetn low during DRAW with draw_req high -> next cycle draw_req=0, state IDLE, all outputs at reset values. With ROW_SPEEDUP_EN, row 3 tick from x=144 -> x=134.
